// File: rtl/time_base_gen.sv
// Multi-channel programmable time base: each channel divides clk by div+1 and
// emits a registered tick strobe plus a 50%-duty divided clock, periodic or one-shot.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_RUN  | channel counting (holds while en is low)
// ST_DONE | one-shot expired; waits for sync or a write
module time_base_gen #(
   parameter int CLK_FREQ = 25000000,
   parameter int CH       = 4,
   parameter int DIV_W    = 25,
   parameter int SEL_W    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CH-1:0]    en,
   input  logic [CH-1:0]    mode,
   input  logic             sync,
   input  logic             div_wr,
   input  logic [SEL_W-1:0] div_sel,
   input  logic [DIV_W-1:0] div_data,
   output logic             div_ack,
   output logic             div_err,
   output logic [CH-1:0]    tick,
   output logic [CH-1:0]    clk_out,
   output logic [CH-1:0]    done
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_FREQ - 1);

   state_t           state_q   [CH];
   state_t           state_nxt [CH];
   logic [DIV_W-1:0] div_q     [CH];
   logic [DIV_W-1:0] div_nxt   [CH];
   logic [DIV_W-1:0] cnt_q     [CH];
   logic [DIV_W-1:0] cnt_nxt   [CH];
   logic [CH-1:0]    tick_nxt;
   logic [CH-1:0]    clk_out_nxt;
   logic [CH-1:0]    sel_hit;
   logic             wr_valid;

   // Decode by equality per channel so an out-of-range select never indexes the arrays.
   always_comb begin
      sel_hit = '0;
      for (int i = 0; i < CH; i++) begin
         if (div_wr && ({1'b0, div_sel} == (SEL_W+1)'(i))) begin
            sel_hit[i] = 1'b1;
         end
      end
   end

   assign wr_valid = |sel_hit;

   always_comb begin
      tick_nxt    = '0;
      clk_out_nxt = clk_out;
      for (int i = 0; i < CH; i++) begin
         state_nxt[i] = state_q[i];
         div_nxt[i]   = div_q[i];
         cnt_nxt[i]   = cnt_q[i];
         if (sync || sel_hit[i]) begin
            // Restart outranks the terminal event, so a coinciding tick is swallowed.
            state_nxt[i]   = ST_RUN;
            cnt_nxt[i]     = '0;
            clk_out_nxt[i] = 1'b0;
            if (sel_hit[i]) begin
               div_nxt[i] = div_data;
            end
         end else if (state_q[i] == ST_DONE) begin
            cnt_nxt[i] = '0;
         end else if (en[i]) begin
            if (cnt_q[i] == div_q[i]) begin
               cnt_nxt[i]     = '0;
               tick_nxt[i]    = 1'b1;
               clk_out_nxt[i] = ~clk_out[i];
               if (mode[i]) begin
                  state_nxt[i] = ST_DONE;
               end
            end else begin
               cnt_nxt[i] = cnt_q[i] + DIV_W'(1);
            end
         end
      end
   end

   always_comb begin
      done = '0;
      for (int i = 0; i < CH; i++) begin
         done[i] = (state_q[i] == ST_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= ST_RUN;
            div_q[i]   <= DIV_RST;
            cnt_q[i]   <= '0;
         end
         tick    <= '0;
         clk_out <= '0;
         div_ack <= 1'b0;
         div_err <= 1'b0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= state_nxt[i];
            div_q[i]   <= div_nxt[i];
            cnt_q[i]   <= cnt_nxt[i];
         end
         tick    <= tick_nxt;
         clk_out <= clk_out_nxt;
         div_ack <= div_wr;
         div_err <= div_wr && !wr_valid;
      end
   end

endmodule

// File: tb/tb_time_base_gen.sv
// Directed bench for time_base_gen: short divisors, one task per scenario,
// expected values hand-computed from the cycle-by-cycle counting rules.
`timescale 1ns/1ps
module tb_time_base_gen;
   localparam int CLK_FREQ = 10;
   localparam int CH       = 4;
   localparam int DIV_W    = 25;
   localparam int SEL_W    = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [CH-1:0]    en;
   logic [CH-1:0]    mode;
   logic             sync;
   logic             div_wr;
   logic [SEL_W-1:0] div_sel;
   logic [DIV_W-1:0] div_data;
   logic             div_ack;
   logic             div_err;
   logic [CH-1:0]    tick;
   logic [CH-1:0]    clk_out;
   logic [CH-1:0]    done;

   int total = 0;
   int bad   = 0;

   time_base_gen #(
      .CLK_FREQ(CLK_FREQ), .CH(CH), .DIV_W(DIV_W), .SEL_W(SEL_W)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sync(sync),
      .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data),
      .div_ack(div_ack), .div_err(div_err), .tick(tick),
      .clk_out(clk_out), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_ch(input logic [SEL_W-1:0] sel, input logic [DIV_W-1:0] data);
      div_wr   = 1'b1;
      div_sel  = sel;
      div_data = data;
      step(1);
      div_wr   = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = '0; mode = '0; sync = 1'b0;
      div_wr = 1'b0; div_sel = '0; div_data = '0;
      step(2);
      total++;
      if ({tick, clk_out, done} !== '0) begin
         bad++; $display("FAIL reset_outs got=%b exp=0", {tick, clk_out, done});
      end
      total++;
      if ({div_ack, div_err} !== 2'b00) begin
         bad++; $display("FAIL reset_ack got=%b exp=00", {div_ack, div_err});
      end
      rst = 1'b0;
      step(1);
      total++;
      if ({tick, clk_out, done, div_ack, div_err} !== '0) begin
         bad++; $display("FAIL reset_idle got=%b exp=0", {tick, clk_out, done, div_ack, div_err});
      end
   endtask

   task automatic test_periodic;
      en = 4'b0001; mode = '0;
      write_ch(0, 3);
      total++;
      if ({div_ack, tick[0], clk_out[0]} !== 3'b100) begin
         bad++; $display("FAIL periodic_wr got=%b exp=100", {div_ack, tick[0], clk_out[0]});
      end
      for (int k = 1; k <= 16; k++) begin
         step(1);
         total++;
         if (tick[0] !== (k % 4 == 0)) begin
            bad++; $display("FAIL periodic_tick k=%0d got=%b exp=%b", k, tick[0], (k % 4 == 0));
         end
         total++;
         if (clk_out[0] !== 1'((k / 4) % 2)) begin
            bad++; $display("FAIL periodic_clk k=%0d got=%b exp=%0d", k, clk_out[0], (k / 4) % 2);
         end
         if (k == 1) begin
            total++;
            if (div_ack !== 1'b0) begin
               bad++; $display("FAIL periodic_ack_pulse got=%b exp=0", div_ack);
            end
         end
      end
   endtask

   task automatic test_oneshot;
      mode = 4'b0010; en = 4'b0011;
      write_ch(1, 2);
      total++;
      if (done[1] !== 1'b0) begin
         bad++; $display("FAIL oneshot_start_done got=%b exp=0", done[1]);
      end
      for (int k = 1; k <= 23; k++) begin
         step(1);
         total++;
         if ({tick[1], done[1]} !== {1'(k == 3), 1'(k >= 3)}) begin
            bad++; $display("FAIL oneshot k=%0d got=%b exp=%b%b", k, {tick[1], done[1]}, (k == 3), (k >= 3));
         end
      end
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      total++;
      if ({tick[1], done[1]} !== 2'b00) begin
         bad++; $display("FAIL oneshot_sync got=%b exp=00", {tick[1], done[1]});
      end
      for (int k = 1; k <= 3; k++) begin
         step(1);
         total++;
         if ({tick[1], done[1]} !== {1'(k == 3), 1'(k == 3)}) begin
            bad++; $display("FAIL oneshot_resync k=%0d got=%b", k, {tick[1], done[1]});
         end
      end
   endtask

   task automatic test_enable;
      write_ch(0, 5);
      for (int k = 1; k <= 13; k++) begin
         if (k == 3)  en[0] = 1'b0;
         if (k == 10) en[0] = 1'b1;
         step(1);
         total++;
         if ({tick[0], clk_out[0]} !== {1'(k == 13), 1'(k == 13)}) begin
            bad++; $display("FAIL enable_hold k=%0d got=%b exp=%b%b", k, {tick[0], clk_out[0]}, (k == 13), (k == 13));
         end
      end
   endtask

   task automatic test_div0_invalid;
      en = 4'b0111;
      write_ch(2, 0);
      total++;
      if ({tick[2], clk_out[2]} !== 2'b00) begin
         bad++; $display("FAIL div0_start got=%b exp=00", {tick[2], clk_out[2]});
      end
      for (int k = 1; k <= 12; k++) begin
         if (k == 9) begin
            div_wr = 1'b1; div_sel = 3'd4; div_data = 25'd7;
         end
         step(1);
         div_wr = 1'b0;
         total++;
         if ({tick[2], clk_out[2]} !== {1'b1, 1'(k % 2)}) begin
            bad++; $display("FAIL div0 k=%0d got=%b exp=1%0d", k, {tick[2], clk_out[2]}, k % 2);
         end
         if (k == 9) begin
            total++;
            if ({div_ack, div_err, done} !== 6'b11_0010) begin
               bad++; $display("FAIL invalid_wr got=%b exp=110010", {div_ack, div_err, done});
            end
         end
         if (k == 10) begin
            total++;
            if ({div_ack, div_err} !== 2'b00) begin
               bad++; $display("FAIL invalid_wr_pulse got=%b exp=00", {div_ack, div_err});
            end
         end
      end
   endtask

   task automatic test_write_terminal;
      logic et;
      logic ec;
      write_ch(0, 3);
      for (int k = 1; k <= 16; k++) begin
         if (k == 12) begin
            div_wr = 1'b1; div_sel = 3'd0; div_data = 25'd3;
         end
         step(1);
         div_wr = 1'b0;
         if (k < 12) begin
            et = (k % 4 == 0); ec = 1'((k / 4) % 2);
         end else begin
            et = (k == 16); ec = (k == 16);
         end
         total++;
         if ({tick[0], clk_out[0]} !== {et, ec}) begin
            bad++; $display("FAIL wr_terminal k=%0d got=%b exp=%b%b", k, {tick[0], clk_out[0]}, et, ec);
         end
      end
   endtask

   task automatic test_sync_write;
      logic [CH-1:0] exp_tick [5];
      logic [CH-1:0] exp_clk  [5];
      logic [CH-1:0] exp_done [5];
      exp_tick = '{4'b0000, 4'b0100, 4'b1100, 4'b0110, 4'b1101};
      exp_clk  = '{4'b0000, 4'b0100, 4'b1000, 4'b1110, 4'b0011};
      exp_done = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
      en = 4'b1111; mode = 4'b0010;
      sync = 1'b1; div_wr = 1'b1; div_sel = 3'd3; div_data = 25'd1;
      step(1);
      sync = 1'b0; div_wr = 1'b0;
      total++;
      if (div_ack !== 1'b1) begin
         bad++; $display("FAIL sync_wr_ack got=%b exp=1", div_ack);
      end
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) step(1);
         total++;
         if ({tick, clk_out, done} !== {exp_tick[k], exp_clk[k], exp_done[k]}) begin
            bad++; $display("FAIL sync_wr k=%0d got=%b_%b_%b exp=%b_%b_%b", k, tick, clk_out, done,
                            exp_tick[k], exp_clk[k], exp_done[k]);
         end
      end
   endtask

   task automatic test_back_to_back;
      en = '0; mode = '0;
      write_ch(0, 3);
      total++;
      if (div_ack !== 1'b1) begin
         bad++; $display("FAIL b2b_ack0 got=%b exp=1", div_ack);
      end
      write_ch(1, 2);
      total++;
      if (div_ack !== 1'b1) begin
         bad++; $display("FAIL b2b_ack1 got=%b exp=1", div_ack);
      end
      step(1);
      total++;
      if ({div_ack, div_err} !== 2'b00) begin
         bad++; $display("FAIL b2b_idle got=%b exp=00", {div_ack, div_err});
      end
   endtask

   task automatic test_reset_midrun;
      logic [CH-1:0] et;
      en = 4'b1111; mode = '0;
      step(3);
      rst = 1'b1; div_wr = 1'b1; div_sel = 3'd0; div_data = 25'd2;
      step(1);
      rst = 1'b0; div_wr = 1'b0;
      total++;
      if ({tick, clk_out, done, div_ack, div_err} !== '0) begin
         bad++; $display("FAIL midrun_rst got=%b exp=0", {tick, clk_out, done, div_ack, div_err});
      end
      for (int k = 1; k <= 20; k++) begin
         step(1);
         et = (k == 10 || k == 20) ? 4'b1111 : 4'b0000;
         total++;
         if (tick !== et) begin
            bad++; $display("FAIL midrun_tick k=%0d got=%b exp=%b", k, tick, et);
         end
         if (k == 1) begin
            total++;
            if (div_ack !== 1'b0) begin
               bad++; $display("FAIL midrun_wr_discard got=%b exp=0", div_ack);
            end
         end
         if (k == 10) begin
            total++;
            if (clk_out !== 4'b1111) begin
               bad++; $display("FAIL midrun_clk got=%b exp=1111", clk_out);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_periodic;
      test_oneshot;
      test_enable;
      test_div0_invalid;
      test_write_terminal;
      test_sync_write;
      test_back_to_back;
      test_reset_midrun;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
